// File: rtl/video_tbl_modulator_ctl_if.sv
// Wishbone slave window of the threshold-table modulator controller.
interface video_tbl_modulator_ctl_if #(
    parameter int unsigned WB_ADR_BITS = 8,
    parameter int unsigned WB_DAT_BITS = 32
);
    logic [WB_ADR_BITS-1:0]   s_wb_adr_i;
    logic [WB_DAT_BITS-1:0]   s_wb_dat_i;
    logic [WB_DAT_BITS/8-1:0] s_wb_sel_i;
    logic                     s_wb_we_i;
    logic                     s_wb_stb_i;
    logic [WB_DAT_BITS-1:0]   s_wb_dat_o;
    logic                     s_wb_ack_o;

    modport master (
        output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o
    );
endinterface

// File: rtl/video_tbl_modulator_ctl.sv
// Control/sequencer for the threshold-table modulator core: host register window,
// table write port (host forwarding or saturating ramp generator) and frame-aligned
// commit of the end/invert parameters.
module video_tbl_modulator_ctl #(
    parameter int unsigned          WB_ADR_BITS = 8,
    parameter int unsigned          WB_DAT_BITS = 32,
    parameter int unsigned          ADDR_BITS   = 6,
    parameter int unsigned          TDATA_BITS  = 24,
    parameter logic [31:0]          CORE_ID     = 32'h527a_0110,
    parameter logic [ADDR_BITS-1:0] INIT_END    = ADDR_BITS'(2**ADDR_BITS - 1),
    parameter logic                 INIT_INV    = 1'b0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aclken,
    video_tbl_modulator_ctl_if.slave wb,
    input  logic                  frame_start,
    output logic [ADDR_BITS-1:0]  param_end,
    output logic                  param_inv,
    output logic                  tbl_wr_en,
    output logic [ADDR_BITS-1:0]  tbl_wr_addr,
    output logic [TDATA_BITS-1:0] tbl_wr_din,
    output logic                  busy
);

    localparam logic [WB_ADR_BITS-1:0] REG_CORE_ID   = WB_ADR_BITS'(8'h00);
    localparam logic [WB_ADR_BITS-1:0] REG_CONTROL   = WB_ADR_BITS'(8'h04);
    localparam logic [WB_ADR_BITS-1:0] REG_STATUS    = WB_ADR_BITS'(8'h05);
    localparam logic [WB_ADR_BITS-1:0] REG_PARAM_END = WB_ADR_BITS'(8'h08);
    localparam logic [WB_ADR_BITS-1:0] REG_PARAM_INV = WB_ADR_BITS'(8'h09);
    localparam logic [WB_ADR_BITS-1:0] REG_GEN_BASE  = WB_ADR_BITS'(8'h0C);
    localparam logic [WB_ADR_BITS-1:0] REG_GEN_STEP  = WB_ADR_BITS'(8'h0D);

    typedef enum logic [0:0] {StIdle, StGen} state_e;

    state_e state_q, state_d;

    // Generator datapath
    logic [ADDR_BITS-1:0]  gen_idx_q, gen_idx_d;
    logic [ADDR_BITS-1:0]  end_g_q, end_g_d;
    logic [TDATA_BITS:0]   acc_q, acc_d;
    logic [TDATA_BITS:0]   acc_sum;
    logic [TDATA_BITS-1:0] acc_sat;

    // Table write port
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [TDATA_BITS-1:0] wr_din_q, wr_din_d;

    // Register file
    logic [ADDR_BITS-1:0]  shadow_end_q, shadow_end_d;
    logic                  shadow_inv_q, shadow_inv_d;
    logic [ADDR_BITS-1:0]  active_end_q, active_end_d;
    logic                  active_inv_q, active_inv_d;
    logic [TDATA_BITS-1:0] gen_base_q, gen_base_d;
    logic [TDATA_BITS-1:0] gen_step_q, gen_step_d;
    logic                  pending_q, pending_d;

    // Bus side
    logic                   ack_q, ack_d;
    logic [WB_DAT_BITS-1:0] dat_o_q, dat_o_d;
    logic                   is_tbl;
    logic                   tbl_stall;
    logic                   accept;
    logic                   reg_wr;
    logic                   tbl_wr;
    logic                   reg_rd;
    logic                   gen_start;
    logic                   update_req;
    logic                   commit;
    logic [WB_DAT_BITS-1:0] rdata;
    logic                   gen_busy;
    logic                   unused_wb;

    // Byte selects are ignored and only the low data bits reach narrow registers.
    assign unused_wb = ^{wb.s_wb_sel_i, wb.s_wb_dat_i};

    assign gen_busy = (state_q == StGen);

    // Carry bit of the accumulator is sticky: once set, the ramp saturates.
    assign acc_sum = {1'b0, acc_q[TDATA_BITS-1:0]} + {1'b0, gen_step_q};
    assign acc_sat = acc_q[TDATA_BITS] ? {TDATA_BITS{1'b1}} : acc_q[TDATA_BITS-1:0];

    // Decode the bus request; table writes wait while the generator owns the write port.
    always_comb begin
        is_tbl     = wb.s_wb_adr_i[WB_ADR_BITS-1];
        tbl_stall  = wb.s_wb_stb_i & wb.s_wb_we_i & is_tbl & gen_busy;
        accept     = wb.s_wb_stb_i & ~ack_q & ~tbl_stall;
        reg_wr     = accept & wb.s_wb_we_i & ~is_tbl;
        tbl_wr     = accept & wb.s_wb_we_i & is_tbl;
        reg_rd     = accept & ~wb.s_wb_we_i;
        gen_start  = reg_wr & (wb.s_wb_adr_i == REG_CONTROL) & wb.s_wb_dat_i[1];
        update_req = reg_wr & (wb.s_wb_adr_i == REG_CONTROL) & wb.s_wb_dat_i[0];
        commit     = frame_start & pending_q & ~gen_busy;
        rdata      = '0;
        if (!is_tbl) begin
            case (wb.s_wb_adr_i)
                REG_CORE_ID:   rdata = WB_DAT_BITS'(CORE_ID);
                REG_STATUS:    rdata = WB_DAT_BITS'({pending_q, gen_busy});
                REG_PARAM_END: rdata = WB_DAT_BITS'(shadow_end_q);
                REG_PARAM_INV: rdata = WB_DAT_BITS'(shadow_inv_q);
                REG_GEN_BASE:  rdata = WB_DAT_BITS'(gen_base_q);
                REG_GEN_STEP:  rdata = WB_DAT_BITS'(gen_step_q);
                default:       rdata = '0;
            endcase
        end
    end

    // FSM next state and table write port: host writes in IDLE, ramp writes in GEN.
    always_comb begin
        state_d   = state_q;
        gen_idx_d = gen_idx_q;
        end_g_d   = end_g_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_din_d  = wr_din_q;
        unique case (state_q)
            StIdle: begin
                if (gen_start) begin
                    state_d   = StGen;
                    gen_idx_d = '0;
                    end_g_d   = shadow_end_q;
                    acc_d     = {1'b0, gen_base_q};
                end
                if (tbl_wr) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wb.s_wb_adr_i[ADDR_BITS-1:0];
                    wr_din_d  = wb.s_wb_dat_i[TDATA_BITS-1:0];
                end
            end
            StGen: begin
                wr_en_d   = 1'b1;
                wr_addr_d = gen_idx_q;
                wr_din_d  = acc_sat;
                gen_idx_d = gen_idx_q + ADDR_BITS'(1);
                acc_d     = {acc_q[TDATA_BITS] | acc_sum[TDATA_BITS], acc_sum[TDATA_BITS-1:0]};
                if (gen_idx_q == end_g_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file, pending flag and frame-aligned commit of shadow parameters.
    always_comb begin
        shadow_end_d = shadow_end_q;
        shadow_inv_d = shadow_inv_q;
        active_end_d = active_end_q;
        active_inv_d = active_inv_q;
        gen_base_d   = gen_base_q;
        gen_step_d   = gen_step_q;
        pending_d    = pending_q;
        ack_d        = accept;
        dat_o_d      = reg_rd ? rdata : '0;
        if (reg_wr) begin
            case (wb.s_wb_adr_i)
                REG_PARAM_END: shadow_end_d = wb.s_wb_dat_i[ADDR_BITS-1:0];
                REG_PARAM_INV: shadow_inv_d = wb.s_wb_dat_i[0];
                REG_GEN_BASE:  gen_base_d   = wb.s_wb_dat_i[TDATA_BITS-1:0];
                REG_GEN_STEP:  gen_step_d   = wb.s_wb_dat_i[TDATA_BITS-1:0];
                default:       ;
            endcase
        end
        // Commit uses the registered shadows, so a same-cycle shadow write waits a frame.
        if (commit) begin
            active_end_d = shadow_end_q;
            active_inv_d = shadow_inv_q;
            pending_d    = 1'b0;
        end
        // A new request arriving with a commit stays pending.
        if (update_req) begin
            pending_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else if (aclken) begin
            state_q <= state_d;
        end
    end

    // Datapath and register-file state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            gen_idx_q    <= '0;
            end_g_q      <= '0;
            acc_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_din_q     <= '0;
            shadow_end_q <= INIT_END;
            shadow_inv_q <= INIT_INV;
            active_end_q <= INIT_END;
            active_inv_q <= INIT_INV;
            gen_base_q   <= '0;
            gen_step_q   <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            dat_o_q      <= '0;
        end else if (aclken) begin
            gen_idx_q    <= gen_idx_d;
            end_g_q      <= end_g_d;
            acc_q        <= acc_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_din_q     <= wr_din_d;
            shadow_end_q <= shadow_end_d;
            shadow_inv_q <= shadow_inv_d;
            active_end_q <= active_end_d;
            active_inv_q <= active_inv_d;
            gen_base_q   <= gen_base_d;
            gen_step_q   <= gen_step_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            dat_o_q      <= dat_o_d;
        end
    end

    assign wb.s_wb_ack_o = ack_q;
    assign wb.s_wb_dat_o = dat_o_q;
    assign param_end     = active_end_q;
    assign param_inv     = active_inv_q;
    assign tbl_wr_en     = wr_en_q;
    assign tbl_wr_addr   = wr_addr_q;
    assign tbl_wr_din    = wr_din_q;
    assign busy          = gen_busy | pending_q;

endmodule

// File: tb/tb_video_tbl_modulator_ctl.sv
// Bench for video_tbl_modulator_ctl: directed sequence plus randomized ramps checked
// against an arithmetic model of the ramp and of the shadow/active parameters.
module tb_video_tbl_modulator_ctl;
    localparam logic [7:0] A_ID   = 8'h00;
    localparam logic [7:0] A_CTRL = 8'h04;
    localparam logic [7:0] A_STAT = 8'h05;
    localparam logic [7:0] A_END  = 8'h08;
    localparam logic [7:0] A_INV  = 8'h09;
    localparam logic [7:0] A_BASE = 8'h0C;
    localparam logic [7:0] A_STEP = 8'h0D;
    localparam int unsigned TMAX  = 32'hFF_FFFF;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aclken = 1'b1;
    logic        frame_start = 1'b0;
    logic [5:0]  param_end;
    logic        param_inv;
    logic        tbl_wr_en;
    logic [5:0]  tbl_wr_addr;
    logic [23:0] tbl_wr_din;
    logic        busy;

    video_tbl_modulator_ctl_if #(.WB_ADR_BITS(8), .WB_DAT_BITS(32)) wb_if ();

    video_tbl_modulator_ctl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aclken      (aclken),
        .wb          (wb_if),
        .frame_start (frame_start),
        .param_end   (param_end),
        .param_inv   (param_inv),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_din  (tbl_wr_din),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Writes the core would accept: wr_en seen with aclken at the next rising edge.
    int unsigned log_addr[$];
    int unsigned log_din[$];
    always @(negedge aclk) begin
        if (aclken && tbl_wr_en) begin
            log_addr.push_back(int'(tbl_wr_addr));
            log_din.push_back(int'(tbl_wr_din));
        end
    end

    // Shadow/active parameter model.
    int unsigned m_end = 63, m_inv = 0, m_act_end = 63, m_act_inv = 0;

    logic        ack_wr_en;
    logic [5:0]  ack_addr;
    logic [23:0] ack_din;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wb_access(input logic [7:0] adr, input logic [31:0] dat, input logic we,
                             output logic [31:0] rdat);
        int n = 0;
        wb_if.s_wb_adr_i = adr;
        wb_if.s_wb_dat_i = dat;
        wb_if.s_wb_we_i  = we;
        wb_if.s_wb_stb_i = 1'b1;
        do begin
            tick(1);
            n++;
        end while (!wb_if.s_wb_ack_o && n < 300);
        if (!wb_if.s_wb_ack_o) check("wb_ack_timeout", wb_if.s_wb_ack_o, 1);
        rdat      = wb_if.s_wb_dat_o;
        ack_wr_en = tbl_wr_en;
        ack_addr  = tbl_wr_addr;
        ack_din   = tbl_wr_din;
        wb_if.s_wb_stb_i = 1'b0;
        wb_if.s_wb_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_access(adr, dat, 1'b1, dummy);
    endtask

    task automatic wb_rd(input logic [7:0] adr, output logic [31:0] rdat);
        wb_access(adr, 32'h0, 1'b0, rdat);
    endtask

    function automatic int unsigned ramp(input int unsigned base, input int unsigned step,
                                         input int unsigned k);
        longint unsigned v;
        v = 64'(base) + 64'(k) * 64'(step);
        return (v > 64'(TMAX)) ? TMAX : int'(v[31:0]);
    endfunction

    task automatic start_gen(input int unsigned base, input int unsigned step,
                             input int unsigned end_g);
        wb_wr(A_BASE, base);
        wb_wr(A_STEP, step);
        wb_wr(A_END, end_g);
        m_end = end_g;
        log_addr.delete();
        log_din.delete();
        wb_wr(A_CTRL, 32'h2);
    endtask

    task automatic wait_writes(input int n);
        int c = 0;
        while (log_addr.size() < n && c < 500) begin
            tick(1);
            c++;
        end
        tick(2);
    endtask

    task automatic check_ramp(input string tag, input int unsigned base,
                              input int unsigned step, input int unsigned end_g);
        check({tag, "_count"}, log_addr.size(), end_g + 1);
        for (int k = 0; k <= int'(end_g) && k < log_addr.size(); k++) begin
            check({tag, "_addr"}, log_addr[k], k);
            check({tag, "_din"}, log_din[k], ramp(base, step, k));
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int unsigned b, s, e;
        logic [5:0]  a0;
        logic [23:0] d0;

        wb_if.s_wb_adr_i = '0;
        wb_if.s_wb_dat_i = '0;
        wb_if.s_wb_sel_i = 4'hF;
        wb_if.s_wb_we_i  = 1'b0;
        wb_if.s_wb_stb_i = 1'b0;

        // Reset state
        tick(3);
        check("rst_param_end", param_end, 63);
        check("rst_param_inv", param_inv, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", tbl_wr_en, 0);
        check("rst_ack", wb_if.s_wb_ack_o, 0);
        check("rst_dat_o", wb_if.s_wb_dat_o, 0);
        aresetn = 1'b1;
        tick(1);
        wb_rd(A_ID, r);
        check("core_id", r, 32'h527a_0110);
        wb_rd(A_STAT, r);
        check("status_idle", r, 0);
        wb_rd(8'h33, r);
        check("unmapped_read", r, 0);

        // Basic ramp with STATUS busy before/after
        start_gen(10, 3, 3);
        wb_rd(A_STAT, r);
        check("t1_status_busy", r[0], 1);
        wait_writes(4);
        wb_rd(A_STAT, r);
        check("t1_status_idle", r[0], 0);
        check_ramp("t1", 10, 3, 3);

        // Saturation
        start_gen(32'hFF_FFF0, 32'h10, 2);
        wait_writes(3);
        check_ramp("t2", 32'hFF_FFF0, 32'h10, 2);

        // Single entry
        start_gen(32'h12_3456, 7, 0);
        wait_writes(1);
        tick(3);
        check_ramp("end0", 32'h12_3456, 7, 0);

        // Randomized ramps
        for (int it = 0; it < 5; it++) begin
            b = $urandom_range(0, TMAX);
            s = (it % 2 == 0) ? $urandom_range(0, 32'h3_FFFF) : $urandom_range(0, TMAX);
            e = $urandom_range(0, 63);
            start_gen(b, s, e);
            wait_writes(int'(e) + 1);
            check_ramp("rnd", b, s, e);
        end

        // Readback of shadow registers
        wb_rd(A_END, r);
        check("rd_shadow_end", r, m_end);

        // Commit waits for frame_start
        wb_wr(A_INV, 1);
        m_inv = 1;
        wb_wr(A_CTRL, 1);
        check("t3_busy_pending", busy, 1);
        wb_rd(A_STAT, r);
        check("t3_status_pending", r, 2);
        tick(3);
        check("t3_inv_held", param_inv, m_act_inv);
        pulse_frame();
        m_act_inv = m_inv;
        m_act_end = m_end;
        check("t3_inv_commit", param_inv, m_act_inv);
        check("t3_end_commit", param_end, m_act_end);
        check("t3_busy_clear", busy, 0);
        wb_rd(A_STAT, r);
        check("t3_status_clear", r, 0);

        // frame_start during GEN defers the commit
        wb_wr(A_INV, 0);
        m_inv = 0;
        wb_wr(A_CTRL, 1);
        start_gen(100, 1, 30);
        tick(3);
        pulse_frame();
        check("defer_inv_held", param_inv, m_act_inv);
        check("defer_end_held", param_end, m_act_end);
        wait_writes(31);
        check("defer_busy_pending", busy, 1);
        wb_rd(A_STAT, r);
        check("defer_status", r, 2);
        pulse_frame();
        m_act_inv = m_inv;
        m_act_end = m_end;
        check("defer_inv_commit", param_inv, m_act_inv);
        check("defer_end_commit", param_end, m_act_end);
        check("defer_busy_clear", busy, 0);

        // Host table write during GEN is stalled until the ramp completes
        b = $urandom_range(0, TMAX);
        s = $urandom_range(0, 32'hFFFF);
        start_gen(b, s, 20);
        wb_wr(8'h85, 32'h12AB_CDEF);
        check("t4_ack_wr_en", ack_wr_en, 1);
        check("t4_ack_addr", ack_addr, 5);
        check("t4_ack_din", ack_din, 32'hAB_CDEF);
        tick(2);
        check("t4_total", log_addr.size(), 22);
        if (log_addr.size() == 22) begin
            check("t4_host_addr", log_addr[21], 5);
            check("t4_host_din", log_din[21], 32'hAB_CDEF);
            void'(log_addr.pop_back());
            void'(log_din.pop_back());
            check_ramp("t4", b, s, 20);
        end
        wb_rd(8'h85, r);
        check("t4_table_read_zero", r, 0);

        // aclken low mid-GEN freezes the write port
        b = $urandom_range(0, TMAX);
        s = $urandom_range(0, 32'h3_FFFF);
        start_gen(b, s, 15);
        tick(5);
        a0 = tbl_wr_addr;
        d0 = tbl_wr_din;
        aclken = 1'b0;
        tick(5);
        check("t6_addr_frozen", tbl_wr_addr, a0);
        check("t6_din_frozen", tbl_wr_din, d0);
        check("t6_busy_held", busy, 1);
        aclken = 1'b1;
        wait_writes(16);
        tick(3);
        check_ramp("t6", b, s, 15);

        // Reset mid-GEN, with active parameters away from their reset values
        wb_wr(A_INV, 1);
        wb_wr(A_END, 17);
        wb_wr(A_CTRL, 1);
        pulse_frame();
        check("t5_pre_inv", param_inv, 1);
        check("t5_pre_end", param_end, 17);
        start_gen(5, 5, 40);
        tick(5);
        aresetn = 1'b0;
        tick(1);
        check("t5_wr_en", tbl_wr_en, 0);
        check("t5_busy", busy, 0);
        check("t5_param_end", param_end, 63);
        check("t5_param_inv", param_inv, 0);
        aresetn = 1'b1;
        m_end = 63; m_inv = 0; m_act_end = 63; m_act_inv = 0;
        log_addr.delete();
        log_din.delete();
        tick(10);
        check("t5_no_writes", log_addr.size(), 0);
        wb_rd(A_END, r);
        check("t5_shadow_end", r, m_end);
        wb_rd(A_INV, r);
        check("t5_shadow_inv", r, m_inv);
        wb_rd(A_STAT, r);
        check("t5_status", r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
